// File: rtl/ram_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : ram_read_port
//  Purpose  : Registered read stage for one RAM port. Captures the word
//             presented on 'word' whenever the port is clock-enabled and
//             holds it otherwise. Async active-low reset clears the output.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset (output register only)
//             ce    - port clock enable
//             word  - word currently addressed in the array
//             q     - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module ram_read_port #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (ce) begin
         q <= word;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dp_ram_r2w1.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_r2w1
//  Purpose  : Synchronous RAM with one read/write port (A) and one read-only
//             port (B), single clock, 1-cycle registered reads, read-first
//             behaviour on same-address collisions.
//  Ports    : clk, rst_n           - clock / async active-low reset
//                                    (reset clears read registers only)
//             a_ce, a_we, a_addr,
//             a_write, a_read      - port A enable, write enable, address,
//                                    write data, registered read data
//             b_ce, b_addr, b_read - port B enable, address, read data
//             b_we, b_write        - present for interface compatibility,
//                                    have no effect
//  Revision : 1.0  initial release
// ============================================================================
module dp_ram_r2w1 #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_ce,
   input  logic [DATA_W-1:0] a_write,
   output logic [DATA_W-1:0] a_read,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic              b_ce,
   input  logic [DATA_W-1:0] b_write,
   output logic [DATA_W-1:0] b_read
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] a_word;
   logic [DATA_W-1:0] b_word;

   // Port B write signals are deliberately discarded.
   logic unused_b_write;
   assign unused_b_write = ^{b_we, b_write};

   // Array write. Not reset: contents survive reset, and writes stay
   // enabled while rst_n is low.
   always_ff @(posedge clk) begin
      if (a_ce && a_we) begin
         mem[a_addr] <= a_write;
      end
   end

   // Both read registers sample the array on the same edge as the write,
   // so they see the pre-write word (read-first).
   assign a_word = mem[a_addr];
   assign b_word = mem[b_addr];

   ram_read_port #(
      .DATA_W (DATA_W)
   ) u_read_a (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (a_ce),
      .word  (a_word),
      .q     (a_read)
   );

   ram_read_port #(
      .DATA_W (DATA_W)
   ) u_read_b (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (b_ce),
      .word  (b_word),
      .q     (b_read)
   );

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_r2w1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_ram_r2w1
//  Purpose  : Directed self-checking bench for dp_ram_r2w1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dp_ram_r2w1;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic              a_ce;
   logic [DATA_W-1:0] a_write;
   logic [DATA_W-1:0] a_read;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic              b_ce;
   logic [DATA_W-1:0] b_write;
   logic [DATA_W-1:0] b_read;

   int vectors;
   int miscompares;

   dp_ram_r2w1 #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_ce    (a_ce),
      .a_write (a_write),
      .a_read  (a_read),
      .b_we    (b_we),
      .b_addr  (b_addr),
      .b_ce    (b_ce),
      .b_write (b_write),
      .b_read  (b_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_ce = 1'b0; a_we = 1'b0; b_ce = 1'b0; b_we = 1'b0;
   endtask

   task automatic write_a(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      idle();
      a_ce = 1'b1; a_we = 1'b1; a_addr = addr; a_write = data;
      step();
      idle();
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      a_we    = 1'($urandom);
      a_ce    = 1'($urandom);
      a_addr  = ADDR_W'($urandom);
      a_write = DATA_W'($urandom);
      b_we    = 1'($urandom);
      b_ce    = 1'($urandom);
      b_addr  = ADDR_W'($urandom);
      b_write = DATA_W'($urandom);
      #2; // before the first rising edge at t=5
      vectors++;
      if (a_read !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_a_read: got %h expected %h", a_read, 16'h0000);
      end
      vectors++;
      if (b_read !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_b_read: got %h expected %h", b_read, 16'h0000);
      end
      idle();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      write_a(12'h005, 16'h1234);
      write_a(12'hFFF, 16'hBEEF);
      a_ce = 1'b1; a_addr = 12'hFFF;
      b_ce = 1'b1; b_addr = 12'h005;
      step();
      vectors++;
      if (a_read !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL wr_rd_a_fff: got %h expected %h", a_read, 16'hBEEF);
      end
      vectors++;
      if (b_read !== 16'h1234) begin
         miscompares++;
         $display("FAIL wr_rd_b_005: got %h expected %h", b_read, 16'h1234);
      end
      // back-to-back reads with swapped addresses
      a_addr = 12'h005; b_addr = 12'hFFF;
      step();
      vectors++;
      if (a_read !== 16'h1234 || b_read !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL b2b_swap: got a=%h b=%h expected a=%h b=%h",
                  a_read, b_read, 16'h1234, 16'hBEEF);
      end
      idle();
   endtask

   task automatic test_collision();
      write_a(12'h007, 16'h1111);
      a_ce = 1'b1; a_we = 1'b1; a_addr = 12'h007; a_write = 16'h2222;
      b_ce = 1'b1; b_addr = 12'h007;
      step();
      vectors++;
      if (a_read !== 16'h1111) begin
         miscompares++;
         $display("FAIL rdw_a_old: got %h expected %h", a_read, 16'h1111);
      end
      vectors++;
      if (b_read !== 16'h1111) begin
         miscompares++;
         $display("FAIL rdw_b_old: got %h expected %h", b_read, 16'h1111);
      end
      a_we = 1'b0;
      step();
      vectors++;
      if (b_read !== 16'h2222 || a_read !== 16'h2222) begin
         miscompares++;
         $display("FAIL rdw_new: got a=%h b=%h expected %h", a_read, b_read, 16'h2222);
      end
      idle();
   endtask

   task automatic test_ce_gating();
      write_a(12'h003, 16'h0101);
      a_ce = 1'b1; a_addr = 12'h003;
      b_ce = 1'b1; b_addr = 12'h003;
      step();
      vectors++;
      if (a_read !== 16'h0101 || b_read !== 16'h0101) begin
         miscompares++;
         $display("FAIL ce_pre: got a=%h b=%h expected %h", a_read, b_read, 16'h0101);
      end
      // gated write attempt plus B address change with b_ce low
      a_ce = 1'b0; a_we = 1'b1; a_addr = 12'h003; a_write = 16'h5555;
      b_ce = 1'b0; b_addr = 12'h005;
      step();
      b_addr = 12'hFFF;
      a_addr = 12'h007;
      step();
      vectors++;
      if (b_read !== 16'h0101) begin
         miscompares++;
         $display("FAIL ce_b_hold: got %h expected %h", b_read, 16'h0101);
      end
      vectors++;
      if (a_read !== 16'h0101) begin
         miscompares++;
         $display("FAIL ce_a_hold: got %h expected %h", a_read, 16'h0101);
      end
      idle();
      a_ce = 1'b1; a_addr = 12'h003;
      b_ce = 1'b1; b_addr = 12'h003;
      step();
      vectors++;
      if (a_read !== 16'h0101 || b_read !== 16'h0101) begin
         miscompares++;
         $display("FAIL ce_no_write: got a=%h b=%h expected %h", a_read, b_read, 16'h0101);
      end
      idle();
   endtask

   task automatic test_b_write_ignored();
      write_a(12'h009, 16'h0009);
      b_we = 1'b1; b_ce = 1'b1; b_write = 16'hDEAD; b_addr = 12'h009;
      step();
      vectors++;
      if (b_read !== 16'h0009) begin
         miscompares++;
         $display("FAIL bwe_first: got %h expected %h", b_read, 16'h0009);
      end
      b_we = 1'b0;
      a_ce = 1'b1; a_addr = 12'h009;
      step();
      vectors++;
      if (a_read !== 16'h0009 || b_read !== 16'h0009) begin
         miscompares++;
         $display("FAIL bwe_ignored: got a=%h b=%h expected %h", a_read, b_read, 16'h0009);
      end
      idle();
   endtask

   task automatic test_reset_midrun();
      write_a(12'h002, 16'hCAFE);
      a_ce = 1'b1; a_addr = 12'h002;
      b_ce = 1'b1; b_addr = 12'h002;
      step();
      vectors++;
      if (a_read !== 16'hCAFE || b_read !== 16'hCAFE) begin
         miscompares++;
         $display("FAIL mid_pre: got a=%h b=%h expected %h", a_read, b_read, 16'hCAFE);
      end
      idle();
      #2;
      rst_n = 1'b0;
      #1; // no clock edge in between
      vectors++;
      if (a_read !== 16'h0000 || b_read !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_async_clr: got a=%h b=%h expected %h", a_read, b_read, 16'h0000);
      end
      // write during reset must still land
      a_ce = 1'b1; a_we = 1'b1; a_addr = 12'h004; a_write = 16'h4444;
      b_ce = 1'b1; b_addr = 12'h002;
      step();
      vectors++;
      if (a_read !== 16'h0000 || b_read !== 16'h0000) begin
         miscompares++;
         $display("FAIL mid_held_clr: got a=%h b=%h expected %h", a_read, b_read, 16'h0000);
      end
      idle();
      rst_n = 1'b1;
      step();
      vectors++;
      if (a_read !== 16'h0000 || b_read !== 16'h0000) begin
         miscompares++;
         $display("FAIL post_rst_idle: got a=%h b=%h expected %h", a_read, b_read, 16'h0000);
      end
      a_ce = 1'b1; a_addr = 12'h002;
      b_ce = 1'b1; b_addr = 12'h004;
      step();
      vectors++;
      if (a_read !== 16'hCAFE) begin
         miscompares++;
         $display("FAIL post_rst_a_cafe: got %h expected %h", a_read, 16'hCAFE);
      end
      vectors++;
      if (b_read !== 16'h4444) begin
         miscompares++;
         $display("FAIL rst_write_b_4444: got %h expected %h", b_read, 16'h4444);
      end
      idle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_collision();
      test_ce_gating();
      test_b_write_ignored();
      test_reset_midrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dp_ram_r2w1.md
# dp_ram_r2w1

Synchronous dual-port RAM with two read ports and one write port. Port A reads and writes; port B is read-only. It is a block-RAM primitive in the MyHDL-generated memory subsystem and is shaped so synthesis maps it onto a single inferred dual-port RAM. It uses one clock domain with registered (1-cycle) read outputs.

## Interface
- `ADDR_W`, default 12: address width; depth = 2**ADDR_W words.
- `DATA_W`, default 16: word width.

Ports:
- `clk` input, 1 bit: single clock, rising edge, shared by both ports.
- `rst_n` input, 1 bit: reset, asynchronous, active-low; clears the read registers only.
- `a_we` input, 1 bit: port A write enable.
- `a_addr` input, ADDR_W bits: port A address.
- `a_ce` input, 1 bit: port A clock enable (gates both read and write).
- `a_write` input, DATA_W bits: port A write data.
- `a_read` output, DATA_W bits: port A registered read data.
- `b_we` input, 1 bit: kept for interface compatibility; ignored.
- `b_addr` input, ADDR_W bits: port B address.
- `b_ce` input, 1 bit: port B clock enable.
- `b_write` input, DATA_W bits: kept for interface compatibility; ignored.
- `b_read` output, DATA_W bits: port B registered read data.

## Operation
- Storage is an array of 2**ADDR_W words, each DATA_W bits wide. Reset does not clear it, and its power-up contents are undefined.
- Write: on a rising edge with `a_ce`=1 and `a_we`=1, `mem[a_addr]` takes `a_write`.
- Read A: on a rising edge with `a_ce`=1, `a_read` takes `mem[a_addr]`. This happens whether or not a write also occurs.
- Read B: on a rising edge with `b_ce`=1, `b_read` takes `mem[b_addr]`.
- With `ce`=0 on a port, that port's read register holds its value. With `a_ce`=0, no write happens even if `a_we`=1.
- `b_we` and `b_write` never modify memory and have no effect on any output.
- Addresses are used unsigned and are always in range. There is no wrap or overflow logic.

## Timing
- Read latency is 1 cycle. The address and `ce` sampled at edge N produce data on the output after edge N.
- Write latency is 1 cycle. Data written at edge N is readable by a read sampled at edge N+1, which appears after edge N+1.
- Read-during-write on port A to the same address is read-first: `a_read` returns the old word.
- Port B reading the address port A writes on the same edge also returns the old word.
- Reset: asserting `rst_n`=0 forces `a_read`=0 and `b_read`=0 immediately, without waiting for a clock edge.
- While reset is asserted, writes are still allowed if `a_ce` and `a_we` are both high. Memory contents survive reset.
- After `rst_n` rises, the first edge with `ce`=1 loads read data normally.
- Reset asserted mid-operation only zeroes the outputs. Memory contents are preserved.

## Structure
- There are no shared typedefs. `ADDR_W` and `DATA_W` stay module parameters and are not placed in a shared package.
- The natural split is one sub-module, `ram_read_port`: a registered read with clock enable and async reset, instantiated twice (A and B).
- The memory array and the write process live in the top module.
- No vendor primitives are instantiated; the RAM is left to inference.

## Test plan
- Reset: hold `rst_n`=0 with random inputs, then check `a_read`=0x0000 and `b_read`=0x0000 with no clock edge needed.
- Write/read back:
  - write `0x1234` at A addr 5, then `0xBEEF` at addr 0xFFF;
  - read addr 5 via B and 0xFFF via A;
  - required: `b_read`=0x1234 and `a_read`=0xBEEF one cycle after each read.
- Read-first collision:
  - with `mem[7]`=0x1111, write 0x2222 to addr 7 on A while B reads addr 7 on the same edge;
  - required: `a_read`=`b_read`=0x1111 on that edge;
  - next B read of addr 7 returns 0x2222.
- Clock-enable gating:
  - with `a_ce`=0, `a_we`=1, `a_write`=0x5555 at addr 3 (`mem[3]`=0x0101), memory is unchanged;
  - with `b_ce`=0, `b_read` holds its prior value while `b_addr` changes;
  - a later read of addr 3 returns 0x0101.
- Port B write ignored:
  - drive `b_we`=1, `b_ce`=1, `b_write`=0xDEAD at addr 9 (`mem[9]`=0x0009);
  - a read of addr 9 returns 0x0009.
- Reset mid-run:
  - assert `rst_n`=0 between clock edges after writing 0xCAFE to addr 2;
  - outputs go to 0 at once;
  - after release, reading addr 2 returns 0xCAFE.
